// File: rtl/mux_n1_rr_reg_if.sv
// Bundle of the N:1 mux channel-side and output-side handshake signals.
interface mux_n1_rr_reg_if #(
    parameter int unsigned N     = 16,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

    // Channel side: channel k occupies in_data[k*WIDTH +: WIDTH]
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;

    // Channel selection control
    logic               mode;
    logic [SELW-1:0]    sel;

    // Output side
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_chan;
    logic               out_valid;
    logic               out_ready;

    // Producer/consumer environment around the mux
    modport master (
        output in_data,
        output in_valid,
        output mode,
        output sel,
        output out_ready,
        input  in_ready,
        input  out_data,
        input  out_chan,
        input  out_valid
    );

    // The mux itself
    modport slave (
        input  in_data,
        input  in_valid,
        input  mode,
        input  sel,
        input  out_ready,
        output in_ready,
        output out_data,
        output out_chan,
        output out_valid
    );
endinterface

// File: rtl/mux_n1_rr_reg.sv
// N:1 multiplexer with a registered output stage, valid/ready handshakes on
// both sides, and either direct channel select or round-robin scanning.
module mux_n1_rr_reg #(
    parameter int unsigned N     = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_n1_rr_reg_if.slave  bus
);
    localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUMW = SELW + 1;

    // Output register occupancy
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [SELW-1:0]  chan_q;
    logic [SELW-1:0]  chan_d;
    logic [SELW-1:0]  rr_ptr_q;
    logic [SELW-1:0]  rr_ptr_d;

    logic [WIDTH-1:0] chan_data [N];
    logic [N-1:0]     rot_valid;
    logic [SUMW-1:0]  rot_offs;
    logic [SUMW-1:0]  rr_sum;
    logic             rot_found;
    logic [SELW-1:0]  grant;
    logic             grant_vld;
    logic             can_load;
    logic             xfer;
    logic [N-1:0]     ready_c;

    // Unpack the flat input bus into per-channel words
    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign chan_data[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

    // Grant selection: direct select, or first valid at/after rr_ptr
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        rot_valid = '0;
        rot_offs  = '0;
        rot_found = 1'b0;
        rr_sum    = '0;
        if (bus.mode == 1'b0) begin
            grant     = bus.sel;
            grant_vld = (SUMW'(bus.sel) < SUMW'(N));
        end else begin
            // Rotate so that bit 0 corresponds to the channel at rr_ptr
            rot_valid = N'({bus.in_valid, bus.in_valid} >> rr_ptr_q);
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (rot_valid[i]) begin
                    rot_offs  = SUMW'(i);
                    rot_found = 1'b1;
                end
            end
            rr_sum = SUMW'(rr_ptr_q) + rot_offs;
            if (rr_sum >= SUMW'(N)) begin
                rr_sum = rr_sum - SUMW'(N);
            end
            grant     = SELW'(rr_sum);
            grant_vld = rot_found;
        end
    end

    // Handshake qualification; in_ready is held low throughout reset
    always_comb begin
        can_load = (state_q == ST_EMPTY) || bus.out_ready;
        ready_c  = '0;
        for (int k = 0; k < int'(N); k++) begin
            ready_c[k] = rst_n && can_load && grant_vld && (grant == SELW'(k));
        end
        xfer = rst_n && can_load && grant_vld && bus.in_valid[grant];
    end

    // Next-state, output-word load and round-robin pointer advance
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        chan_d   = chan_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (xfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (bus.out_ready && !xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (xfer) begin
            data_d = chan_data[grant];
            chan_d = grant;
            if (bus.mode) begin
                rr_ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // State, output word and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            data_q   <= '0;
            chan_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            chan_q   <= chan_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux_n1_rr_reg.sv
// Directed bench for mux_n1_rr_reg: a 16-channel instance for most scenarios
// and a 12-channel instance for the out-of-range select case.
module tb_mux_n1_rr_reg;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mux_n1_rr_reg_if #(.N(16), .WIDTH(8)) b16 ();
    mux_n1_rr_reg_if #(.N(12), .WIDTH(8)) b12 ();

    mux_n1_rr_reg #(.N(16), .WIDTH(8)) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    mux_n1_rr_reg #(.N(12), .WIDTH(8)) u12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b12.slave)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reset state, then asynchronous reset while a word is held
    task automatic test_reset();
        if (b16.out_valid !== 1'b0 || b16.out_data !== 8'h00 || b16.out_chan !== 4'd0) begin
            $display("FAIL rst_init_out: valid=%b data=%h chan=%0d exp 0/00/0",
                     b16.out_valid, b16.out_data, b16.out_chan);
            fails++;
        end
        tests++;
        if (b16.in_ready !== 16'h0000 || b12.in_ready !== 12'h000) begin
            $display("FAIL rst_init_ready: got %h/%h exp 0000/000", b16.in_ready, b12.in_ready);
            fails++;
        end
        tests++;
        @(negedge clk);
        rst_n         = 1'b1;
        b16.mode      = 1'b0;
        b16.sel       = 4'd4;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        if (b16.out_valid !== 1'b1 || b16.out_chan !== 4'd4 || b16.out_data !== 8'hA4) begin
            $display("FAIL rst_preload: valid=%b chan=%0d data=%h exp 1/4/a4",
                     b16.out_valid, b16.out_chan, b16.out_data);
            fails++;
        end
        tests++;
        b16.out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        if (b16.out_valid !== 1'b0 || b16.out_data !== 8'h00 || b16.out_chan !== 4'd0 ||
            b16.in_ready !== 16'h0000) begin
            $display("FAIL rst_async: valid=%b data=%h chan=%0d ready=%h exp 0/00/0/0000",
                     b16.out_valid, b16.out_data, b16.out_chan, b16.in_ready);
            fails++;
        end
        tests++;
        @(negedge clk);
        b16.in_valid  = '0;
        b16.out_ready = 1'b1;
        rst_n         = 1'b1;
        @(posedge clk); #1;
    endtask

    // Mode 0: sweep sel over every channel with all inputs valid
    task automatic test_mode0_sweep();
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            b16.mode      = 1'b0;
            b16.sel       = 4'(s);
            b16.in_valid  = 16'hFFFF;
            b16.out_ready = 1'b1;
            #1;
            if (b16.in_ready !== (16'h0001 << s)) begin
                $display("FAIL sweep_ready[%0d]: got %h exp %h", s, b16.in_ready, 16'h0001 << s);
                fails++;
            end
            tests++;
            @(posedge clk); #1;
            if (b16.out_valid !== 1'b1 || b16.out_chan !== 4'(s) || b16.out_data !== 8'(8'hA0 + s)) begin
                $display("FAIL sweep_out[%0d]: valid=%b chan=%0d data=%h exp 1/%0d/%h",
                         s, b16.out_valid, b16.out_chan, b16.out_data, s, 8'(8'hA0 + s));
                fails++;
            end
            tests++;
        end
        @(negedge clk);
        b16.in_valid = '0;
        @(posedge clk); #1;
        if (b16.out_valid !== 1'b0) begin
            $display("FAIL sweep_drain: out_valid=%b exp 0", b16.out_valid);
            fails++;
        end
        tests++;
    endtask

    // Mode 0 with sel beyond the last channel of a 12-channel mux
    task automatic test_mode0_oor();
        @(negedge clk);
        b12.mode      = 1'b0;
        b12.sel       = 4'd13;
        b12.in_valid  = 12'hFFF;
        b12.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (b12.in_ready !== 12'h000) begin
                $display("FAIL oor_ready[%0d]: got %h exp 000", c, b12.in_ready);
                fails++;
            end
            tests++;
            @(posedge clk); #1;
            if (b12.out_valid !== 1'b0) begin
                $display("FAIL oor_valid[%0d]: got %b exp 0", c, b12.out_valid);
                fails++;
            end
            tests++;
            @(negedge clk);
        end
        b12.sel = 4'd11;
        #1;
        if (b12.in_ready !== 12'h800) begin
            $display("FAIL oor_last_ready: got %h exp 800", b12.in_ready);
            fails++;
        end
        tests++;
        @(posedge clk); #1;
        if (b12.out_valid !== 1'b1 || b12.out_chan !== 4'd11 || b12.out_data !== 8'h3B) begin
            $display("FAIL oor_last_out: valid=%b chan=%0d data=%h exp 1/11/3b",
                     b12.out_valid, b12.out_chan, b12.out_data);
            fails++;
        end
        tests++;
        @(negedge clk);
        b12.in_valid = '0;
    endtask

    // Mode 1: three continuous requesters served in rotation
    task automatic test_rr_fair();
        int exp_chan [6] = '{2, 5, 15, 2, 5, 15};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            b16.mode      = 1'b1;
            b16.in_valid  = 16'h8024;
            b16.out_ready = 1'b1;
            #1;
            if (b16.in_ready !== (16'h0001 << exp_chan[i])) begin
                $display("FAIL rr_ready[%0d]: got %h exp %h", i, b16.in_ready, 16'h0001 << exp_chan[i]);
                fails++;
            end
            tests++;
            @(posedge clk); #1;
            if (b16.out_valid !== 1'b1 || b16.out_chan !== 4'(exp_chan[i]) ||
                b16.out_data !== 8'(8'hA0 + exp_chan[i])) begin
                $display("FAIL rr_out[%0d]: valid=%b chan=%0d data=%h exp 1/%0d",
                         i, b16.out_valid, b16.out_chan, b16.out_data, exp_chan[i]);
                fails++;
            end
            tests++;
        end
        @(negedge clk);
        b16.in_valid = '0;
        @(posedge clk); #1;
    endtask

    // Output stall holds the word; release resumes with no bubble
    task automatic test_backpressure();
        @(negedge clk);
        b16.mode      = 1'b0;
        b16.sel       = 4'd3;
        b16.in_valid  = 16'hFFFF;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        if (b16.out_chan !== 4'd3 || b16.out_valid !== 1'b1) begin
            $display("FAIL bp_load: chan=%0d valid=%b exp 3/1", b16.out_chan, b16.out_valid);
            fails++;
        end
        tests++;
        @(negedge clk);
        b16.out_ready = 1'b0;
        b16.sel       = 4'd7;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (b16.in_ready !== 16'h0000) begin
                $display("FAIL bp_ready[%0d]: got %h exp 0000", c, b16.in_ready);
                fails++;
            end
            tests++;
            @(posedge clk); #1;
            if (b16.out_valid !== 1'b1 || b16.out_chan !== 4'd3 || b16.out_data !== 8'hA3) begin
                $display("FAIL bp_hold[%0d]: valid=%b chan=%0d data=%h exp 1/3/a3",
                         c, b16.out_valid, b16.out_chan, b16.out_data);
                fails++;
            end
            tests++;
            @(negedge clk);
        end
        b16.out_ready = 1'b1;
        b16.mode      = 1'b1;
        b16.in_valid  = 16'h0080;
        #1;
        if (b16.in_ready !== 16'h0080) begin
            $display("FAIL bp_release_ready: got %h exp 0080", b16.in_ready);
            fails++;
        end
        tests++;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (b16.out_valid !== 1'b1 || b16.out_chan !== 4'd7 || b16.out_data !== 8'hA7) begin
                $display("FAIL bp_release_out[%0d]: valid=%b chan=%0d data=%h exp 1/7/a7",
                         c, b16.out_valid, b16.out_chan, b16.out_data);
                fails++;
            end
            tests++;
        end
        @(negedge clk);
        b16.in_valid = '0;
        @(posedge clk); #1;
    endtask

    // Mode-0 transfers leave the round-robin pointer where mode 1 left it
    task automatic test_mode_switch();
        // Pointer is 8 here; channel 5 alone wins and moves it to 6
        @(negedge clk);
        b16.mode      = 1'b1;
        b16.in_valid  = 16'h0020;
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        if (b16.out_chan !== 4'd5 || b16.out_data !== 8'hA5) begin
            $display("FAIL sw_setptr: chan=%0d data=%h exp 5/a5", b16.out_chan, b16.out_data);
            fails++;
        end
        tests++;
        @(negedge clk);
        b16.mode     = 1'b0;
        b16.sel      = 4'd1;
        b16.in_valid = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (b16.out_valid !== 1'b1 || b16.out_chan !== 4'd1 || b16.out_data !== 8'hA1) begin
                $display("FAIL sw_mode0[%0d]: valid=%b chan=%0d data=%h exp 1/1/a1",
                         c, b16.out_valid, b16.out_chan, b16.out_data);
                fails++;
            end
            tests++;
        end
        @(negedge clk);
        b16.mode     = 1'b1;
        b16.in_valid = 16'h0202;
        #1;
        if (b16.in_ready !== 16'h0200) begin
            $display("FAIL sw_first_ready: got %h exp 0200", b16.in_ready);
            fails++;
        end
        tests++;
        @(posedge clk); #1;
        if (b16.out_chan !== 4'd9 || b16.out_data !== 8'hA9) begin
            $display("FAIL sw_first_out: chan=%0d data=%h exp 9/a9", b16.out_chan, b16.out_data);
            fails++;
        end
        tests++;
        @(negedge clk); #1;
        if (b16.in_ready !== 16'h0002) begin
            $display("FAIL sw_second_ready: got %h exp 0002", b16.in_ready);
            fails++;
        end
        tests++;
        @(posedge clk); #1;
        if (b16.out_chan !== 4'd1 || b16.out_data !== 8'hA1) begin
            $display("FAIL sw_second_out: chan=%0d data=%h exp 1/a1", b16.out_chan, b16.out_data);
            fails++;
        end
        tests++;
        @(negedge clk);
        b16.in_valid = '0;
        #1;
        if (b16.in_ready !== 16'h0000) begin
            $display("FAIL sw_idle_ready: got %h exp 0000", b16.in_ready);
            fails++;
        end
        tests++;
        @(posedge clk); #1;
        if (b16.out_valid !== 1'b0) begin
            $display("FAIL sw_idle_valid: got %b exp 0", b16.out_valid);
            fails++;
        end
        tests++;
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        b16.mode      = 1'b0;
        b16.sel       = '0;
        b16.in_valid  = 16'hFFFF;
        b16.out_ready = 1'b0;
        b12.mode      = 1'b0;
        b12.sel       = '0;
        b12.in_valid  = '0;
        b12.out_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            b16.in_data[k*8 +: 8] = 8'(8'hA0 + k);
        end
        for (int k = 0; k < 12; k++) begin
            b12.in_data[k*8 +: 8] = 8'(8'h30 + k);
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mode0_sweep();
        test_mode0_oor();
        test_rr_fair();
        test_backpressure();
        test_mode_switch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
